// File: rtl/morse_char_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : morse_char_ctrl
// Description : Morse element timer, classifier and character decoder with a
//               small ASCII output FIFO. Marks shorter than 2 dot units are
//               dots; a space of 2 dot units ends a character. Optional
//               word-gap emission (0x20 after 5 dot units of space) is
//               enabled by defining MORSE_CTRL_WORDGAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_char_ctrl #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             morse,
  input  logic [CNT_W-1:0] dot_len,
  input  logic             dot_len_valid,
  input  logic             read_en,
  output logic [7:0]       ascii_out,
  output logic             empty,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SPACE = 2'd1;
  localparam logic [1:0] ST_MARK  = 2'd2;
  localparam logic [1:0] ST_EMIT  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment shared by both duration counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ITU table; code holds the first element in bit 0, dash = 1.
  function automatic logic [7:0] decode_char(input logic [5:0] code, input logic [2:0] len);
    logic [7:0] ch;
    ch = 8'h3F;
    case ({len, code})
      {3'd1, 6'd0}:  ch = 8'h45; // E
      {3'd1, 6'd1}:  ch = 8'h54; // T
      {3'd2, 6'd0}:  ch = 8'h49; // I
      {3'd2, 6'd1}:  ch = 8'h4E; // N
      {3'd2, 6'd2}:  ch = 8'h41; // A
      {3'd2, 6'd3}:  ch = 8'h4D; // M
      {3'd3, 6'd0}:  ch = 8'h53; // S
      {3'd3, 6'd1}:  ch = 8'h44; // D
      {3'd3, 6'd2}:  ch = 8'h52; // R
      {3'd3, 6'd3}:  ch = 8'h47; // G
      {3'd3, 6'd4}:  ch = 8'h55; // U
      {3'd3, 6'd5}:  ch = 8'h4B; // K
      {3'd3, 6'd6}:  ch = 8'h57; // W
      {3'd3, 6'd7}:  ch = 8'h4F; // O
      {3'd4, 6'd0}:  ch = 8'h48; // H
      {3'd4, 6'd1}:  ch = 8'h42; // B
      {3'd4, 6'd2}:  ch = 8'h4C; // L
      {3'd4, 6'd3}:  ch = 8'h5A; // Z
      {3'd4, 6'd4}:  ch = 8'h46; // F
      {3'd4, 6'd5}:  ch = 8'h43; // C
      {3'd4, 6'd6}:  ch = 8'h50; // P
      {3'd4, 6'd8}:  ch = 8'h56; // V
      {3'd4, 6'd9}:  ch = 8'h58; // X
      {3'd4, 6'd11}: ch = 8'h51; // Q
      {3'd4, 6'd13}: ch = 8'h59; // Y
      {3'd4, 6'd14}: ch = 8'h4A; // J
      {3'd5, 6'd0}:  ch = 8'h35; // 5
      {3'd5, 6'd1}:  ch = 8'h36; // 6
      {3'd5, 6'd3}:  ch = 8'h37; // 7
      {3'd5, 6'd7}:  ch = 8'h38; // 8
      {3'd5, 6'd15}: ch = 8'h39; // 9
      {3'd5, 6'd16}: ch = 8'h34; // 4
      {3'd5, 6'd24}: ch = 8'h33; // 3
      {3'd5, 6'd28}: ch = 8'h32; // 2
      {3'd5, 6'd30}: ch = 8'h31; // 1
      {3'd5, 6'd31}: ch = 8'h30; // 0
      default:       ch = 8'h3F;
    endcase
    return ch;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] dot_q, dot_d;
  logic             dot_seen_q, dot_seen_d;
  logic [CNT_W-1:0] mark_cnt_q, mark_cnt_d;
  logic [CNT_W-1:0] space_cnt_q, space_cnt_d;
  logic [5:0]       code_q, code_d;
  logic [2:0]       elem_len_q, elem_len_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic             overflow_q, overflow_d;

  logic [CNT_W+2:0] w_t2;
  logic [CNT_W-1:0] w_space_inc;
  logic             w_space_t2_hit, w_is_dash;
  logic             w_push, w_gap_push, w_pop, w_push_ok, w_full, w_empty;
  logic [7:0]       w_push_char;

  // Thresholds are kept 3 bits wider than the counters so 5*dot never wraps.
  assign w_t2           = {2'b00, dot_q, 1'b0};
  assign w_space_inc    = sat_inc(space_cnt_q);
  assign w_space_t2_hit = ({3'b000, w_space_inc} >= w_t2);
  assign w_is_dash      = ({3'b000, mark_cnt_q} >= w_t2);

`ifdef MORSE_CTRL_WORDGAP_EN
  logic [CNT_W+2:0] w_t5;
  logic             gap_arm_q, gap_arm_d;

  assign w_t5       = {1'b0, dot_q, 2'b00} + {3'b000, dot_q};
  assign w_gap_push = (state_q == ST_SPACE) && !morse && (elem_len_q == 3'd0) &&
                      gap_arm_q && ({3'b000, w_space_inc} >= w_t5);

  // Arm word-gap emission once a character has been emitted; disarm after one space.
  always_comb begin
    gap_arm_d = gap_arm_q;
    if (state_q == ST_EMIT)
      gap_arm_d = 1'b1;
    else if (w_gap_push)
      gap_arm_d = 1'b0;
  end

  // Word-gap arm flag register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) gap_arm_q <= 1'b0;
    else         gap_arm_q <= gap_arm_d;
  end
`else
  assign w_gap_push = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (dot_seen_q && !morse) state_d = ST_SPACE;
      ST_SPACE: begin
        if (morse)
          state_d = ST_MARK;
        else if ((elem_len_q != 3'd0) && w_space_t2_hit)
          state_d = ST_EMIT;
      end
      ST_MARK:  if (!morse) state_d = ST_SPACE;
      ST_EMIT:  state_d = ST_SPACE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: FIFO push request/data and busy indication.
  always_comb begin
    w_push      = 1'b0;
    w_push_char = 8'h00;
    if (state_q == ST_EMIT) begin
      w_push      = 1'b1;
      w_push_char = decode_char(code_q, elem_len_q);
    end else if (w_gap_push) begin
      w_push      = 1'b1;
      w_push_char = 8'h20;
    end
  end

  assign busy = (state_q != ST_IDLE) && (elem_len_q != 3'd0);

  // Datapath: dot unit, duration counters and the partial character.
  always_comb begin
    dot_d       = dot_q;
    dot_seen_d  = dot_seen_q;
    mark_cnt_d  = mark_cnt_q;
    space_cnt_d = space_cnt_q;
    code_d      = code_q;
    elem_len_d  = elem_len_q;
    if (dot_len_valid) begin
      dot_d      = (dot_len == '0) ? CNT_ONE : dot_len;
      dot_seen_d = 1'b1;
    end
    case (state_q)
      ST_SPACE: begin
        if (morse) mark_cnt_d  = CNT_ONE;
        else       space_cnt_d = w_space_inc;
      end
      ST_MARK: begin
        if (morse) begin
          mark_cnt_d = sat_inc(mark_cnt_q);
        end else begin
          space_cnt_d = CNT_ONE;
          if (elem_len_q < 3'd6) begin
            code_d     = code_q | ({5'b00000, w_is_dash} << elem_len_q);
            elem_len_d = elem_len_q + 3'd1;
          end else begin
            elem_len_d = 3'd7; // sticky "too many elements" marker
          end
        end
      end
      ST_EMIT: begin
        space_cnt_d = w_space_inc;
        code_d      = 6'd0;
        elem_len_d  = 3'd0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dot_q       <= CNT_ONE;
      dot_seen_q  <= 1'b0;
      mark_cnt_q  <= '0;
      space_cnt_q <= '0;
      code_q      <= 6'd0;
      elem_len_q  <= 3'd0;
    end else begin
      dot_q       <= dot_d;
      dot_seen_q  <= dot_seen_d;
      mark_cnt_q  <= mark_cnt_d;
      space_cnt_q <= space_cnt_d;
      code_q      <= code_d;
      elem_len_q  <= elem_len_d;
    end
  end

  // FIFO control: a pop frees the slot for a same-cycle push when full.
  assign w_empty   = (wr_ptr_q == rd_ptr_q);
  assign w_full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign w_pop     = read_en && !w_empty;
  assign w_push_ok = w_push && (!w_full || w_pop);

  // FIFO next-state: storage, pointers and sticky overflow.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (w_push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = w_push_char;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (w_pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && w_full && !w_pop)
      overflow_d = 1'b1;
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign empty     = w_empty;
  assign ascii_out = w_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_char_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_char_ctrl
// Description : Self-checking bench for morse_char_ctrl: directed scenarios
//               plus randomized keying checked against a pattern-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_char_ctrl;

  localparam int CNT_W      = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef MORSE_CTRL_WORDGAP_EN
  localparam bit WORDGAP = 1'b1;
`else
  localparam bit WORDGAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             morse = 1'b0;
  logic [CNT_W-1:0] dot_len = '0;
  logic             dot_len_valid = 1'b0;
  logic             read_en = 1'b0;
  logic [7:0]       ascii_out;
  logic             empty, overflow, busy;

  int total = 0;
  int bad   = 0;

  morse_char_ctrl #(.CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .morse(morse), .dot_len(dot_len),
    .dot_len_valid(dot_len_valid), .read_en(read_en), .ascii_out(ascii_out),
    .empty(empty), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Patterns for A..Z then 0..9.
  string sym_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                          "--...", "---..", "----."};

  function automatic logic [7:0] ref_decode(input string pat);
    for (int i = 0; i < 36; i++)
      if (sym_tab[i] == pat) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
    return 8'h3F;
  endfunction

  task automatic drive(input logic lvl, input int n);
    morse = lvl;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input int d);
    dot_len = d[CNT_W-1:0]; dot_len_valid = 1'b1; morse = 1'b0;
    @(posedge clk); #1;
    dot_len_valid = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0; morse = 1'b0; read_en = 1'b0; dot_len_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  task automatic pop();
    read_en = 1'b1; @(posedge clk); #1; read_en = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; #1;
    total++; if (ascii_out !== 8'h00) begin bad++; $display("FAIL rst_ascii: got %02h want 00", ascii_out); end
    total++; if (empty !== 1'b1)      begin bad++; $display("FAIL rst_empty: got %0b want 1", empty); end
    total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    do_reset();
    // Without a dot_len strobe the controller stays idle and ignores keying.
    drive(1, 12); drive(0, 25); drive(1, 30); drive(0, 30);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL idle_empty: got %0b want 1", empty); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_letter_a();
    do_reset(); strobe(10); drive(0, 3);
    drive(1, 10); drive(0, 10); drive(1, 30); drive(0, 20);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL a_emit_empty: got %0b want 1", empty); end
    total++; if (busy !== 1'b1)  begin bad++; $display("FAIL a_emit_busy: got %0b want 1", busy); end
    drive(0, 1);
    total++; if (empty !== 1'b0)     begin bad++; $display("FAIL a_empty: got %0b want 0", empty); end
    total++; if (ascii_out !== 8'h41) begin bad++; $display("FAIL a_char: got %02h want 41", ascii_out); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL a_busy: got %0b want 0", busy); end
    drive(0, 19); pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL a_pop_empty: got %0b want 1", empty); end
  endtask

  task automatic test_digit_zero();
    do_reset(); strobe(10); drive(0, 3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 30);
      if (i != 4) drive(0, 10);
    end
    drive(0, 25);
    total++; if (ascii_out !== 8'h30) begin bad++; $display("FAIL zero_char: got %02h want 30", ascii_out); end
    pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL zero_single: got %0b want 1", empty); end
  endtask

  task automatic test_invalid();
    do_reset(); strobe(10); drive(0, 3);
    for (int i = 0; i < 7; i++) begin
      drive(1, 10);
      if (i == 6) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL inv_busy_mid: got %0b want 1", busy); end
      end else drive(0, 10);
    end
    drive(0, 20);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL inv_busy_emit: got %0b want 1", busy); end
    drive(0, 1);
    total++; if (ascii_out !== 8'h3F) begin bad++; $display("FAIL inv_char: got %02h want 3f", ascii_out); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL inv_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_wordgap();
    logic [7:0] exp_q [$];
    do_reset(); strobe(10); drive(0, 3);
    drive(1, 10); drive(0, 60);
    exp_q.push_back(8'h45);
    if (WORDGAP) exp_q.push_back(8'h20);
    while (exp_q.size() != 0) begin
      total++;
      if (empty !== 1'b0 || ascii_out !== exp_q[0]) begin
        bad++; $display("FAIL wordgap_char: got %02h (empty=%0b) want %02h", ascii_out, empty, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pop();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wordgap_end: got %0b want 1", empty); end
  endtask

  task automatic test_overflow();
    do_reset(); strobe(10); drive(0, 3);
    for (int i = 0; i < 5; i++) begin
      drive(1, 10); drive(0, 30);
      if (i == 3) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_only: got %0b want 0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (empty !== 1'b0 || ascii_out !== 8'h45) begin bad++; $display("FAIL ovf_held%0d: got %02h want 45", i, ascii_out); end
      pop();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_drained: got %0b want 1", empty); end
    // Fifth push lands on the same edge as a pop of a full FIFO.
    do_reset(); strobe(10); drive(0, 3);
    for (int i = 0; i < 4; i++) begin drive(1, 10); drive(0, 30); end
    drive(1, 10); drive(0, 20);
    read_en = 1'b1; drive(0, 1); read_en = 1'b0; drive(0, 9);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_coincident: got %0b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (empty !== 1'b0 || ascii_out !== 8'h45) begin bad++; $display("FAIL ovf_keep%0d: got %02h want 45", i, ascii_out); end
      pop();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_keep_end: got %0b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    do_reset(); strobe(10); drive(0, 3);
    drive(1, 10); drive(0, 30);
    drive(1, 10); drive(0, 10); drive(1, 30); drive(0, 10); drive(1, 15);
    total++; if (busy !== 1'b1 || empty !== 1'b0) begin bad++; $display("FAIL mid_pre: got busy=%0b empty=%0b want 1 0", busy, empty); end
    arst_n = 1'b0; #2;
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
    total++; if (empty !== 1'b1)      begin bad++; $display("FAIL mid_empty: got %0b want 1", empty); end
    total++; if (ascii_out !== 8'h00) begin bad++; $display("FAIL mid_ascii: got %02h want 00", ascii_out); end
    @(posedge clk); #1 arst_n = 1'b1;
    drive(1, 20); drive(0, 25); drive(1, 30); drive(0, 30);
    total++; if (empty !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_idle: got empty=%0b busy=%0b want 1 0", empty, busy); end
    strobe(10); drive(0, 3); drive(1, 30); drive(0, 25);
    total++; if (ascii_out !== 8'h54) begin bad++; $display("FAIL mid_t: got %02h want 54", ascii_out); end
    pop();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_t_only: got %0b want 1", empty); end
  endtask

  task automatic test_dot_zero();
    // dot_len = 0 acts as one cycle: a 2-cycle mark is a dash, 1 cycle a dot.
    do_reset(); strobe(0); drive(0, 3);
    drive(1, 2); drive(0, 1); drive(1, 1); drive(0, 3);
    total++; if (ascii_out !== 8'h4E) begin bad++; $display("FAIL dot0_char: got %02h want 4e", ascii_out); end
  endtask

  task automatic test_random();
    int         run_len [$];
    bit         run_lvl [$];
    logic [7:0] exp_q [$];
    int         d, n, m, g;
    bit         armed;
    string      pat;
    do_reset();
    d = int'($urandom_range(3, 8));
    strobe(d);
    run_lvl.push_back(1'b0); run_len.push_back(3);
    armed = 1'b0;
    for (int c = 0; c < 30; c++) begin
      n = int'($urandom_range(1, 7));
      pat = "";
      for (int e = 0; e < n; e++) begin
        case ($urandom_range(0, 3))
          0:       m = int'($urandom_range(1, 2 * d - 1));
          1:       m = 2 * d - 1;
          2:       m = 2 * d;
          default: m = int'($urandom_range(2 * d, 4 * d));
        endcase
        if (m < 2 * d) pat = {pat, "."}; else pat = {pat, "-"};
        run_lvl.push_back(1'b1); run_len.push_back(m);
        if (e != n - 1) begin run_lvl.push_back(1'b0); run_len.push_back(int'($urandom_range(1, 2 * d - 1))); end
      end
      exp_q.push_back(ref_decode(pat));
      armed = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        g = int'($urandom_range(5 * d, 7 * d));
        if (WORDGAP) begin exp_q.push_back(8'h20); armed = 1'b0; end
      end else begin
        g = int'($urandom_range(2 * d + 1, 5 * d - 1));
      end
      run_lvl.push_back(1'b0); run_len.push_back(g);
    end
    run_lvl.push_back(1'b0); run_len.push_back(6 * d);
    if (WORDGAP && armed) exp_q.push_back(8'h20);
    for (int r = 0; r < run_len.size(); r++) begin
      for (int k = 0; k < run_len[r]; k++) begin
        morse   = run_lvl[r];
        read_en = 1'b0;
        if (!empty) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rand_extra: got %02h want nothing", ascii_out);
          end else begin
            if (ascii_out !== exp_q[0]) begin bad++; $display("FAIL rand_char: got %02h want %02h", ascii_out, exp_q[0]); end
            void'(exp_q.pop_front());
          end
          read_en = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
    read_en = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_missing: got %0d left want 0", exp_q.size()); end
    total++; if (empty !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL rand_end: got empty=%0b ovf=%0b want 1 0", empty, overflow); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_digit_zero();
    test_invalid();
    test_wordgap();
    test_overflow();
    test_reset_mid();
    test_dot_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
